data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//  Responder end of the MEM-stage data-memory interface. Accepts read/write requests
//  (memRead/memWrite, ALU address, store data) from the MEM stage, services them with a
//  fixed multi-cycle latency and holds the pipeline with 'stall' until done.
//  Replaces the single-cycle combinational data memory in front of MEM/WB.
// PARAMETERS
//  DEPTH_WORDS  256  number of 32-bit words in the backing array (power of 2)
//  LATENCY      3    cycles spent in BUSY per access; must be >= 1 (elaboration error if 0)
// PORTS
//  clk         in   1   single clock, rising edge
//  rst         in   1   asynchronous, active-high reset
//  memRead     in   1   read request from MEM stage (level, held while stalled)
//  memWrite    in   1   write request from MEM stage (level, held while stalled)
//  addr        in   32  byte address (ALU result); word index = addr[31:2]
//  writeData   in   32  store data
//  readData    out  32  load data, valid when ready=1, held until next read completes
//  stall       out  1   freeze PC/IF/ID/EX/MEM registers this cycle
//  ready       out  1   one-cycle pulse: access completed this cycle
//  err         out  1   one-cycle pulse with ready: misaligned or out-of-range access
// BEHAVIOUR
//  Reset (async): state=IDLE, readData=0, ready=0, err=0, count=0; array NOT cleared.
//  FSM states IDLE, BUSY, RESP:
//   IDLE: req = memRead|memWrite. On req: latch addr/writeData/op, count=LATENCY-1, ->BUSY.
//         Both asserted -> treated as write (write has priority).
//   BUSY: count decrements each cycle; at count==0 perform access, ->RESP.
//         Write: array[idx]<=wdata_latched. Read: readData<=array[idx].
//   RESP: ready=1 (err=1 if bad access), stall=0 so pipeline advances; ->IDLE.
//         Request inputs are ignored in RESP (same instruction still present).
//  stall = (IDLE & req) | BUSY  (combinational; asserts in the request cycle itself).
//  Latency: request seen in cycle 0 -> ready in cycle LATENCY+1; stall high cycles
//   0..LATENCY (LATENCY+1 cycles total); next request accepted in IDLE at cycle LATENCY+2.
//  Bad access: addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS -> write dropped, read returns 0,
//   err=1 in RESP; timing identical to a good access.
//  Inputs captured only on IDLE->BUSY; changes during BUSY have no effect.
//  Reset mid-operation: return to IDLE immediately, pending write aborted (array unchanged),
//   readData=0, no ready pulse.
//  count width = $clog2(LATENCY+1); no wrap: decrement only while count>0.
//  No request in IDLE: stall=0, ready=0, outputs hold.
// STRUCTURE
//  Shared header mips_mem_defs.vh: state encodings (S_IDLE=2'd0, S_BUSY=2'd1, S_RESP=2'd2),
//   WORD_BYTES=4, default DEPTH_WORDS/LATENCY.
//  One sub-module: mem_word_array (DEPTH_WORDS x 32, sync write enable, sync read,
//   no reset on storage). FSM, counter, address check and output registers in top level.
// TESTING
//  1 LATENCY=3: write 0xDEADBEEF @0x10, then read @0x10 -> stall high 4 cycles each,
//    ready pulse cycle 4, readData=0xDEADBEEF.
//  2 Read @0x13 (misaligned) and @0x400 (DEPTH=256) -> readData=0, err=1 with ready;
//    write @0x400 then read @0x0 -> @0x0 unchanged.
//  3 memRead=memWrite=1, addr=0x20, data=0x5 -> treated as write; later read 0x20 -> 0x5.
//  4 Change addr/writeData during BUSY -> access uses cycle-0 values only.
//  5 Assert rst during BUSY of write 0x1234 @0x8 -> no ready, stall=0 after reset,
//    read @0x8 returns pre-existing value.
//  6 Back-to-back loads (req held continuously) -> ready every LATENCY+2 cycles,
//    never two accesses for one instruction; LATENCY=1 variant: stall 2 cycles.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared types, constants and address-check helper for the MEM-stage data-memory responder.
package data_mem_responder_pkg;

    localparam int unsigned WORD_BYTES      = 4;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned DEF_DEPTH_WORDS = 256;
    localparam int unsigned DEF_LATENCY     = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // A byte address is bad when it is not word aligned or its word index falls past the array.
    function automatic logic addr_is_bad(input logic [ADDR_W-1:0] a, input int unsigned depth);
        return (a[1:0] != 2'b00) || (a[ADDR_W-1:2] >= 30'(depth));
    endfunction

endpackage

// File: rtl/data_mem_responder_mem_word_array.sv
// Word-wide backing store: synchronous write, registered synchronous read, storage not reset.
module mem_word_array
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Write port and registered read port; the read register holds between read enables.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: accepts one MEM-stage request, stalls the pipeline
// for LATENCY busy cycles, then pulses ready (and err for a bad address) for one cycle.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int unsigned LATENCY     = DEF_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData,
    output logic              stall,
    output logic              ready,
    output logic              err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

    if (LATENCY < 1) begin : g_bad_latency
        $error("data_mem_responder: LATENCY must be at least 1");
    end
    if ((DEPTH_WORDS < 2) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_bad_depth
        $error("data_mem_responder: DEPTH_WORDS must be a power of two >= 2");
    end

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_nxt;

    // Request captured on acceptance; later input changes are ignored.
    logic               op_write_q;
    logic               bad_q;
    logic [IDX_W-1:0]   idx_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               op_write_nxt;
    logic               bad_nxt;
    logic [IDX_W-1:0]   idx_nxt;
    logic [DATA_W-1:0]  wdata_nxt;

    logic               ready_nxt;
    logic               err_nxt;
    logic [DATA_W-1:0]  read_data_nxt;

    logic               req;
    logic               arr_we;
    logic               arr_re;
    logic [DATA_W-1:0]  arr_rdata;

    assign req = memRead | memWrite;

    // The array read is launched on acceptance so its registered output is ready
    // by the last busy cycle, where it is transferred into readData.
    mem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (idx_q),
        .wdata (wdata_q),
        .re    (arr_re),
        .raddr (addr[IDX_W+1:2]),
        .rdata (arr_rdata)
    );

    // State, counter, captured request and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            count      <= '0;
            op_write_q <= 1'b0;
            bad_q      <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            ready      <= 1'b0;
            err        <= 1'b0;
            readData   <= '0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            op_write_q <= op_write_nxt;
            bad_q      <= bad_nxt;
            idx_q      <= idx_nxt;
            wdata_q    <= wdata_nxt;
            ready      <= ready_nxt;
            err        <= err_nxt;
            readData   <= read_data_nxt;
        end
    end

    // Next-state, access control and combinational stall.
    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        op_write_nxt  = op_write_q;
        bad_nxt       = bad_q;
        idx_nxt       = idx_q;
        wdata_nxt     = wdata_q;
        ready_nxt     = 1'b0;
        err_nxt       = 1'b0;
        read_data_nxt = readData;
        arr_we        = 1'b0;
        arr_re        = 1'b0;
        stall         = 1'b0;

        case (state)
            S_IDLE: begin
                if (req) begin
                    stall        = 1'b1;
                    arr_re       = ~memWrite;
                    op_write_nxt = memWrite;
                    bad_nxt      = addr_is_bad(addr, DEPTH_WORDS);
                    idx_nxt      = addr[IDX_W+1:2];
                    wdata_nxt    = writeData;
                    count_nxt    = CNT_W'(LATENCY - 1);
                    state_nxt    = S_BUSY;
                end
            end
            S_BUSY: begin
                stall = 1'b1;
                if (count == '0) begin
                    state_nxt = S_RESP;
                    ready_nxt = 1'b1;
                    err_nxt   = bad_q;
                    if (op_write_q) begin
                        arr_we = ~bad_q;
                    end else begin
                        read_data_nxt = bad_q ? '0 : arr_rdata;
                    end
                end else begin
                    count_nxt = count - CNT_W'(1);
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
